// File: rtl/fetchq_pkg.sv
// fetchq_pkg: shared widths, NOP encoding and entry type for the fetch queue.
package fetchq_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int INSTR_W_DEF = 32;
    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetchq_mem.sv
// fetchq_mem: DEPTH x W register array, one write port, asynchronous read, no reset.
module fetchq_mem #(
    parameter int DEPTH = 4,
    parameter int W = 64,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fall-through FIFO between fetch and decode, flushed on taken branch.
// Define FETCHQ_STATS_EN to add the saturating discard_count output.
module if_fetch_queue
    import fetchq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     in_freeze,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
`ifdef FETCHQ_STATS_EN
    ,
    output logic [15:0]              discard_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int W = ADDR_W + INSTR_W;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  rdata;
    logic          full, empty, push, pop;

    assign full = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    // Full is taken from the registered count, so a same-cycle pop never frees a slot for push.
    assign push = in_valid && !full && !flush;
    assign pop = !empty && out_ready && !flush;

    always_comb begin
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q <= count_d;
        end
    end

    fetchq_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
        .clk(clk),
        .we(push),
        .waddr(wr_ptr_q),
        .wdata({in_pc, in_instr}),
        .raddr(rd_ptr_q),
        .rdata(rdata)
    );

    assign out_valid = !empty;
    assign out_pc = empty ? '0 : rdata[W-1:INSTR_W];
    assign out_instr = empty ? INSTR_W'(NOP_INSTR) : rdata[INSTR_W-1:0];
    assign in_freeze = full;
    assign count = count_q;

`ifdef FETCHQ_STATS_EN
    logic [15:0] discard_q, discard_d;
    logic [16:0] discard_sum;
    assign discard_sum = {1'b0, discard_q} + 17'(count_q) + 17'(in_valid);
    always_comb begin
        discard_d = !flush ? discard_q : discard_sum[16] ? 16'hFFFF : discard_sum[15:0];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) discard_q <= '0;
        else discard_q <= discard_d;
    end
    assign discard_count = discard_q;
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed stimulus with a scoreboard queue checked by a decoupled monitor.
module tb_if_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 0;
    logic        rst = 0;
    logic        in_valid = 0;
    logic [31:0] in_pc = 0;
    logic [31:0] in_instr = 0;
    logic        in_freeze;
    logic        flush = 0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 0;
    logic [2:0]  count;
`ifdef FETCHQ_STATS_EN
    logic [15:0] discard_count;
    int          mdisc = 0;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int mcount = 0;
    logic [63:0] sb[$];

    if_fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_pc(in_pc),
        .in_instr(in_instr),
        .in_freeze(in_freeze),
        .flush(flush),
        .out_valid(out_valid),
        .out_pc(out_pc),
        .out_instr(out_instr),
        .out_ready(out_ready),
        .count(count)
`ifdef FETCHQ_STATS_EN
        ,
        .discard_count(discard_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decode side: whenever a pop will happen on the next edge, the head must match the oldest expected pair.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready && !flush) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got pc %0h, no entry expected", out_pc);
            end else begin
                if ({out_pc, out_instr} !== sb[0]) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0h expected %0h", {out_pc, out_instr}, sb[0]);
                end
                void'(sb.pop_front());
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
        bit pu, po;
        in_valid = v;
        in_pc = pc;
        in_instr = ins;
        out_ready = rdy;
        flush = fl;
        if (fl) begin
`ifdef FETCHQ_STATS_EN
            mdisc = mdisc + mcount + int'(v);
            if (mdisc > 65535) mdisc = 65535;
`endif
            sb.delete();
            mcount = 0;
        end else begin
            pu = v && mcount < DEPTH;
            po = mcount > 0 && rdy;
            if (pu) sb.push_back({pc, ins});
            mcount = mcount + int'(pu) - int'(po);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        out_ready = 0;
        flush = 0;
    endtask

    initial begin
        #2;
        check("reset_count", 64'(count), 0);
        check("reset_valid", 64'(out_valid), 0);
        check("reset_freeze", 64'(in_freeze), 0);
        check("reset_pc", 64'(out_pc), 0);
        check("reset_instr", 64'(out_instr), 0);
`ifdef FETCHQ_STATS_EN
        check("reset_discard", 64'(discard_count), 0);
`endif
        #10 rst = 1;
        @(posedge clk);
        #1;

        // empty pass-through: one-edge latency
        cyc(1, 32'h100, 32'hE3A01005, 0, 0);
        check("pass_valid", 64'(out_valid), 1);
        check("pass_pc", 64'(out_pc), 64'h100);
        check("pass_instr", 64'(out_instr), 64'hE3A01005);
        cyc(0, 0, 0, 1, 0);
        check("pass_drained", 64'(count), 0);
        check("pass_nop", 64'(out_instr), 0);
        cyc(0, 0, 0, 1, 0);
        check("empty_ready_count", 64'(count), 0);

        // fill and freeze, 5th push dropped
        for (int i = 1; i <= 4; i++) cyc(1, 32'(4 * i), 32'(32'hA000 + i), 0, 0);
        check("fill_count", 64'(count), 4);
        check("fill_freeze", 64'(in_freeze), 1);
        cyc(1, 32'd20, 32'hA005, 0, 0);
        check("fill_drop_count", 64'(count), 4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
        check("drain_count", 64'(count), 0);
        check("drain_valid", 64'(out_valid), 0);

        // concurrent push/pop at count 2, pointers wrap
        cyc(1, 32'h20, 32'hB000, 0, 0);
        cyc(1, 32'h24, 32'hB001, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 32'(32'h28 + 4 * i), 32'(32'hB002 + i), 1, 0);
            check("conc_count", 64'(count), 2);
        end

        // full plus pop: push refused
        cyc(1, 32'h80, 32'hC000, 0, 0);
        cyc(1, 32'h84, 32'hC001, 0, 0);
        check("full_count", 64'(count), 4);
        cyc(1, 32'h99, 32'hDEAD, 1, 0);
        check("fullpop_count", 64'(count), 3);
        check("fullpop_freeze", 64'(in_freeze), 0);

        // flush has priority over push and pop
        cyc(1, 32'h200, 32'hF00D, 1, 1);
        check("flush_count", 64'(count), 0);
        check("flush_valid", 64'(out_valid), 0);
        check("flush_instr", 64'(out_instr), 0);
`ifdef FETCHQ_STATS_EN
        check("flush_discard", 64'(discard_count), 64'(mdisc));
`endif
        cyc(1, 32'h300, 32'h1234, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check("post_flush_count", 64'(count), 0);

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) cyc(1, 32'(32'h400 + 4 * i), 32'(32'hE000 + i), 0, 0);
        check("pre_reset_count", 64'(count), 3);
        rst = 0;
        sb.delete();
        mcount = 0;
        #1;
        check("async_count", 64'(count), 0);
        check("async_valid", 64'(out_valid), 0);
        check("async_instr", 64'(out_instr), 0);
        check("async_freeze", 64'(in_freeze), 0);
`ifdef FETCHQ_STATS_EN
        check("async_discard", 64'(discard_count), 0);
`endif
        @(posedge clk);
        #1 rst = 1;
        cyc(0, 0, 0, 1, 0);
        check("sb_empty", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Decoupling FIFO between the instruction-fetch stage and the decode stage.
- Captures each fetched {PC, instruction} pair and presents the oldest pair to decode.
- Drives back-pressure to fetch through that stage's freeze input.
- Discards all queued entries when a branch is taken.

Parameters:
- ADDR_W, 32, width of the PC field (matches `ADDRESS_LEN).
- INSTR_W, 32, width of the instruction field (matches `INSTRUCTION_LEN).
- DEPTH, 4, number of entries; must be a power of two, at least 2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents a new pair this cycle.
- in_pc  in  ADDR_W  PC value from fetch (address of next sequential instruction).
- in_instr  in  INSTR_W  instruction word from fetch.
- in_freeze  out  1  equals full; connect to the fetch freeze input.
- flush  in  1  branch taken; discard all entries.
- out_valid  out  1  head entry is valid.
- out_pc  out  ADDR_W  PC field of the head entry.
- out_instr  out  INSTR_W  instruction field of the head entry.
- out_ready  in  1  decode consumes the head this cycle (low while decode is frozen).
- count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst low, asynchronous):
  - rd_ptr, wr_ptr and count go to 0.
  - out_valid=0, out_pc=0, out_instr=0, in_freeze=0.
  - Storage contents are don't-care.
- Status signals:
  - full = (count==DEPTH).
  - empty = (count==0).
  - in_freeze = full, driven combinationally from registered count.
- Push: in_valid && !full && !flush. The entry is written at wr_ptr and wr_ptr increments mod DEPTH on the clk edge.
- Pop: out_valid && out_ready && !flush. rd_ptr increments mod DEPTH on the clk edge.
- Output path is first-word fall-through:
  - out_pc/out_instr = storage[rd_ptr] when !empty; forced to 0 when empty (0 is the pipeline NOP).
  - out_valid = !empty.
- Latency: a pair pushed at edge N is visible at the outputs after edge N, i.e. one cycle.
- Count update: push and pop in the same cycle leaves count unchanged and moves both pointers. Push only gives count+1; pop only gives count-1.
- Full plus simultaneous pop: the push is still refused, because full comes from the registered count. There is no combinational ready-to-valid path.
- Empty plus out_ready: no pop; pointers hold.
- Flush has highest priority:
  - On the next edge, count, rd_ptr and wr_ptr go to 0.
  - A same-cycle push is dropped and a same-cycle pop is ignored.
  - out_valid is 0 in the following cycle.
- Pointers are clog2(DEPTH) bits and wrap naturally. count is the sole full/empty source.
- No state machine beyond the pointer/count registers. Occupancy states are EMPTY (0), PARTIAL (1..DEPTH-1) and FULL (DEPTH); transitions follow the rules above.

Optional Feature:
- FETCHQ_STATS_EN defined:
  - Adds output port discard_count, 16 bits.
  - It is a saturating counter of entries discarded by flush: on each flush it adds count, plus 1 if in_valid was high that cycle.
  - Reset value is 0; it saturates at 16'hFFFF.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package fetchq_pkg holds:
  - ADDR_W and INSTR_W defaults.
  - NOP_INSTR constant = 0.
  - Typedef fetch_entry_t {pc, instr}.
- One sub-module is natural: fetchq_mem, a DEPTH x entry register array with one write port and an asynchronous read port, no reset.
- Pointer and count logic stays in the top level.

Test Plan:
- Reset mid-stream: 3 entries queued, rst low for 1 cycle -> count=0, out_valid=0, out_instr=0, in_freeze=0 immediately, with no clock edge needed.
- Fill/freeze: push PCs 4,8,12,16 with out_ready=0 -> count=4, in_freeze=1; a 5th push with PC 20 is dropped; after 4 pops the out_pc sequence is 4,8,12,16.
- Concurrent push/pop: count=2, in_valid=1 and out_ready=1 for 6 cycles -> count stays 2, FIFO order is preserved, pointers wrap past DEPTH.
- Full plus pop: count=4, in_valid=1, out_ready=1 -> the push is refused, count=3 next cycle, in_freeze=0.
- Flush priority: count=3, flush=1 with in_valid=1 and out_ready=1 -> count=0 and out_valid=0 next cycle. With FETCHQ_STATS_EN, discard_count increases by 4.
- Empty pass-through: empty queue, push PC 0x100 with instruction 0xE3A01005 -> out_valid=1, out_pc=0x100, out_instr=0xE3A01005 one edge later.
